// File: rtl/piso_bit_feeder.sv
// piso_bit_feeder: parallel-in/serial-out stage feeding a serial pattern
// detector. Words arrive over valid/ready. One bit is emitted per shift_en
// and presented on registered outputs.
// Optional feature macro: PISO_PARITY_EN appends an even-parity bit to each
// frame, so a frame is WIDTH+1 bits instead of WIDTH.
//
// Handshake: a word is accepted on a rising edge where
// load_valid && load_ready. load_ready is combinational. It is high in IDLE,
// and also on the cycle the last frame bit is being consumed, which allows
// chained words with no bubble. load_data is sampled only on accept.
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    bit_cnt, cnt_nxt;
  logic             out_nxt, valid_nxt;
  logic             last_bit, accept;
  logic             first_bit, adv_bit;
  logic [WIDTH-1:0] adv_reg;
`ifdef PISO_PARITY_EN
  logic             par_q, par_nxt;
`endif

  // The last bit of the frame is the final data bit, or the parity bit when
  // that feature is enabled.
`ifdef PISO_PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (bit_cnt == CW'(WIDTH - 1));
`endif

  assign load_ready = (state == IDLE) || (last_bit && shift_en);
  assign accept     = load_valid && load_ready;
  assign busy       = (state != IDLE);

  // shift_reg keeps the current bit at its output end, so the next bit is
  // always the neighbour of that end.
  assign first_bit = (MSB_FIRST != 0) ? load_data[WIDTH-1] : load_data[0];
  assign adv_bit   = (MSB_FIRST != 0) ? shift_reg[WIDTH-2] : shift_reg[1];
  assign adv_reg   = (MSB_FIRST != 0) ? {shift_reg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shift_reg[WIDTH-1:1]};

  // Next-state and datapath. An accept takes priority and always restarts
  // the frame. Otherwise shift_en advances the frame, and without shift_en
  // every register holds its value.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = bit_cnt;
    out_nxt   = bit_out;
    valid_nxt = bit_valid;
`ifdef PISO_PARITY_EN
    par_nxt   = par_q;
`endif
    if (accept) begin
      state_nxt = SHIFT;
      shift_nxt = load_data;
      cnt_nxt   = '0;
      out_nxt   = first_bit;
      valid_nxt = 1'b1;
`ifdef PISO_PARITY_EN
      par_nxt   = ^load_data;
`endif
    end else begin
      case (state)
        IDLE: begin
          out_nxt   = 1'b0;
          valid_nxt = 1'b0;
        end
        SHIFT: begin
          if (shift_en) begin
            if (bit_cnt == CW'(WIDTH - 1)) begin
`ifdef PISO_PARITY_EN
              state_nxt = PARITY;
              cnt_nxt   = bit_cnt + CW'(1);
              out_nxt   = par_q;
`else
              state_nxt = IDLE;
              cnt_nxt   = '0;
              out_nxt   = 1'b0;
              valid_nxt = 1'b0;
`endif
            end else begin
              shift_nxt = adv_reg;
              cnt_nxt   = bit_cnt + CW'(1);
              out_nxt   = adv_bit;
            end
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          if (shift_en) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
            valid_nxt = 1'b0;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          out_nxt   = 1'b0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State register. Reset discards any word that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath registers, including the registered serial outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      shift_reg <= shift_nxt;
      bit_cnt   <= cnt_nxt;
      bit_out   <= out_nxt;
      bit_valid <= valid_nxt;
`ifdef PISO_PARITY_EN
      par_q     <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_bit_feeder.sv
// tb_piso_bit_feeder: directed bench for piso_bit_feeder (WIDTH=8).
// Two instances share the same inputs: u_msb (MSB_FIRST=1) and u_lsb
// (MSB_FIRST=0). Honors PISO_PARITY_EN for the frame length.
module tb_piso_bit_feeder;

`ifdef PISO_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] load_data = '0;
  logic       load_valid = 1'b0;
  logic       shift_en = 1'b0;
  logic       m_ready, m_out, m_valid, m_busy;
  logic       l_ready, l_out, l_valid, l_busy;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    logic       exp_par;
  } vec_t;
  vec_t vecs[6];

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(m_ready), .shift_en(shift_en), .bit_out(m_out),
    .bit_valid(m_valid), .busy(m_busy)
  );

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .load_data(load_data), .load_valid(load_valid),
    .load_ready(l_ready), .shift_en(shift_en), .bit_out(l_out),
    .bit_valid(l_valid), .busy(l_busy)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] data);
    for (int i = 7; i >= 0; i--) exp_q.push_back(data[i]);
`ifdef PISO_PARITY_EN
    exp_q.push_back(^data);
`endif
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_m_valid"}, {7'd0, m_valid}, 8'd0);
    chk({name, "_m_out"},   {7'd0, m_out},   8'd0);
    chk({name, "_m_busy"},  {7'd0, m_busy},  8'd0);
    chk({name, "_m_ready"}, {7'd0, m_ready}, 8'd1);
    chk({name, "_l_valid"}, {7'd0, l_valid}, 8'd0);
    chk({name, "_l_busy"},  {7'd0, l_busy},  8'd0);
  endtask

  // Accept a word from IDLE and stream one frame with shift_en held high.
  // Both bit orders are checked against the table.
  task automatic send_frame(input vec_t v, input string name);
    logic exp_m, exp_l;
    @(negedge clk);
    load_data  = v.data;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    chk({name, "_ready_idle"}, {7'd0, m_ready & l_ready}, 8'd1);
    @(posedge clk);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      if (i < 8) begin
        exp_m = v.exp_msb[7-i];
        exp_l = v.exp_lsb[7-i];
      end else begin
        exp_m = v.exp_par;
        exp_l = v.exp_par;
      end
      chk($sformatf("%s_m_bit%0d", name, i), {7'd0, m_out}, {7'd0, exp_m});
      chk($sformatf("%s_l_bit%0d", name, i), {7'd0, l_out}, {7'd0, exp_l});
      chk($sformatf("%s_valid%0d", name, i), {6'd0, m_valid, l_valid}, 8'd3);
      chk($sformatf("%s_ready%0d", name, i), {7'd0, m_ready}, {7'd0, (i == FL - 1)});
    end
    @(negedge clk);
    chk_idle({name, "_end"});
  endtask

  initial begin
    int idx, stalled, budget;
    vecs[0] = '{8'hB5, 8'b1011_0101, 8'b1010_1101, 1'b1};
    vecs[1] = '{8'h0F, 8'b0000_1111, 8'b1111_0000, 1'b0};
    vecs[2] = '{8'h01, 8'b0000_0001, 8'b1000_0000, 1'b1};
    vecs[3] = '{8'hC3, 8'b1100_0011, 8'b1100_0011, 1'b0};
    vecs[4] = '{8'hFF, 8'b1111_1111, 8'b1111_1111, 1'b0};
    vecs[5] = '{8'h00, 8'b0000_0000, 8'b0000_0000, 1'b0};

    // Reset state, with shift_en high while idle to show it is ignored.
    #1;
    chk_idle("reset");
    shift_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_idle("idle_shift_en");

    // Single-word frames in both bit orders.
    for (int v = 0; v < 6; v++) send_frame(vecs[v], $sformatf("vec%0d", v));

    // Back-to-back words. The second word is held valid while the first
    // frame is in flight and must be taken only on its last-bit edge.
    exp_q.delete();
    push_word(8'hB5);
    push_word(8'h0F);
    @(negedge clk);
    load_data  = 8'hB5;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load_data = 8'h0F;
    for (int i = 0; i < 2 * FL; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_valid%0d", i), {7'd0, m_valid}, 8'd1);
      chk($sformatf("b2b_bit%0d", i), {7'd0, m_out}, {7'd0, exp_q.pop_front()});
      if (i < FL) chk($sformatf("b2b_ready%0d", i), {7'd0, m_ready}, {7'd0, (i == FL - 1)});
      if (i == FL) load_valid = 1'b0;
    end
    @(negedge clk);
    chk_idle("b2b_end");

    // Stall for three cycles while the third bit is presented.
    exp_q.delete();
    push_word(8'hB5);
    @(negedge clk);
    load_data  = 8'hB5;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    @(posedge clk);
    idx = 0;
    stalled = 0;
    budget = 0;
    while (exp_q.size() > 0 && budget < 40) begin
      @(negedge clk);
      load_valid = 1'b0;
      budget++;
      if (idx == 2 && stalled < 3) begin
        shift_en = 1'b0;
        stalled++;
      end else begin
        shift_en = 1'b1;
      end
      chk($sformatf("stall_valid_c%0d", budget), {7'd0, m_valid}, 8'd1);
      chk($sformatf("stall_bit_c%0d", budget), {7'd0, m_out}, {7'd0, exp_q[0]});
      if (shift_en) begin
        void'(exp_q.pop_front());
        idx++;
      end
    end
    if (exp_q.size() > 0) chk("stall_timeout", 8'd1, 8'd0);
    @(negedge clk);
    chk_idle("stall_end");

    // Asynchronous reset in the middle of a word.
    @(negedge clk);
    load_data  = 8'hB5;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_valid = 1'b0;
      chk($sformatf("rst_pre_bit%0d", i), {7'd0, m_out}, {7'd0, vecs[0].exp_msb[7-i]});
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_idle("rst_async");
    @(negedge clk);
    rst = 1'b0;
    send_frame(vecs[1], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
